pipe_hazard_unit: RTL
=====================

// Module: pipe_hazard_unit
// PURPOSE
// - Parametrised hazard/forwarding controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
// - Supersedes the combinational forwarding + readwrite pair; adds a per-stage scoreboard.
// - Generates load-use stalls, flag-hazard stalls, branch flushes, memory-wait freeze and forward selects.
// - Sits beside the pipeline registers and drives their enable and flush inputs.
// PARAMETERS
// - NREG      32  architectural register count
// - RIDX_W    $clog2(NREG)  register index width
// - ZERO_REG  31  hardwired-zero register (XZR); never a hazard source, never forwarded
// - BR_STAGE  3   stage resolving branches: 2=EX, 3=MEM; sets how many younger stages are flushed
// - CNT_W     16  width of the stall performance counter
// PORTS
// - clk            in   1       clock
// - rst            in   1       synchronous active-high reset
// - id_valid       in   1       ID holds a real instruction
// - id_rn, id_rm   in   RIDX_W  ID source registers (id_rm already post Reg2Loc mux)
// - id_rn_used, id_rm_used  in 1  source is actually read
// - id_rd          in   RIDX_W  ID destination register
// - id_regwrite, id_memread, id_flagset, id_flagread  in 1  ID control bits
// - br_taken       in   1       branch taken, resolved in BR_STAGE
// - mem_req        in   1       MEM stage performs a data access
// - mem_ready      in   1       data memory completes this cycle
// - pc_en, ifid_en out  1       PC / IF_ID write enables
// - idex_bubble    out  1       load zero control into ID_EX
// - flush_ifid, flush_idex, flush_exmem  out 1  squash register contents
// - freeze         out  1       hold ID_EX and EX_MEM; MEM_WB loads a bubble
// - fwd_a, fwd_b   out  2       EX operand selects: 00 reg, 01 WB, 10 MEM
// - byp_a, byp_b   out  1       ID register-file bypass of the WB write data
// - stall_cnt      out  CNT_W   cycles with pc_en=0; saturates at all-ones
// BEHAVIOUR
// - Scoreboard: EX, MEM and WB entries {valid, rn, rm, rd, regwrite, memread, flagset}.
//   - Normal cycle: ID->EX, EX->MEM, MEM->WB.
// - Reset: all entries invalid; pc_en=ifid_en=1; every other output 0; stall_cnt=0.
//   - A reset asserted mid-stall or mid-freeze takes effect at the next edge.
// - Priority per cycle: freeze > branch flush > load-use/flag stall.
// - Freeze: mem_req & !mem_ready.
//   - pc_en=ifid_en=0, freeze=1; EX and MEM entries hold; WB entry becomes invalid.
//   - br_taken is ignored while freeze=1.
// - Branch (br_taken & !freeze): flush_ifid=flush_idex=1; flush_exmem=1 only when BR_STAGE=3.
//   - Flushed scoreboard entries become invalid. pc_en stays 1 (PC loads the target).
// - Load-use: EX valid & memread & regwrite & rd!=ZERO_REG & rd equals a used ID source.
//   - Response: pc_en=ifid_en=0, idex_bubble=1 for exactly one cycle; EX entry becomes invalid.
// - Flag hazard: id_valid & id_flagread & EX valid & flagset -> same one-cycle stall as load-use.
// - Forwarding (combinational from registered entries) for the EX entry's rn/rm.
//   - Source is MEM if MEM valid&regwrite&rd==src&src!=ZERO_REG, else WB on the same test, else reg.
//   - MEM wins over WB.
// - Bypass: byp_a/b=1 when WB valid&regwrite&rd==id source&source!=ZERO_REG.
// - stall_cnt increments on every cycle with pc_en=0 (freeze or stall); it does not wrap.
// - Combinational outputs depend only on scoreboard state and current inputs; no latency.
// STRUCTURE
// - Package pipe_hazard_pkg holds:
//   - typedef sb_entry_t;
//   - enum fwd_sel_t {FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10};
//   - localparams for stage indices.
// - One sub-module, fwd_select: per-operand MEM/WB comparator, instantiated twice (fwd_a, fwd_b).
// TESTING
// - LDUR X1 then ADD X2,X1,X3 -> one cycle pc_en=0, idex_bubble=1; next cycle fwd_a=01; stall_cnt=1.
// - ADD X1 then SUB X4,X1,X1 -> no stall; fwd_a=fwd_b=10.
// - ADD X31 then ADD X5,X31,X31 -> fwd_a=fwd_b=00; no stall.
// - br_taken with BR_STAGE=3 -> flush_ifid=flush_idex=flush_exmem=1 for one cycle.
//   - The stale load-use match in EX is cleared, so no stall follows.
// - mem_req=1, mem_ready=0 for 3 cycles with br_taken=1 -> freeze=1, pc_en=0 for 3 cycles.
//   - No flush while frozen; stall_cnt=3.
// - Assert rst during the load-use stall -> next cycle all entries invalid, pc_en=1, stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard unit: scoreboard entry, forward select
// encoding, stage indices and the register-match helper.
package pipe_hazard_pkg;

  // Scoreboard register fields are stored at this width; narrower indices are zero-extended.
  localparam int RIDX_MAX_W = 8;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [RIDX_MAX_W-1:0] rn;
    logic [RIDX_MAX_W-1:0] rm;
    logic [RIDX_MAX_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  flagset;
  } sb_entry_t;

  // A producer satisfies a source only when it writes that register and it is not XZR.
  function automatic logic reg_hit(
    input logic                  wr,
    input logic [RIDX_MAX_W-1:0] rd,
    input logic [RIDX_MAX_W-1:0] src,
    input logic [RIDX_MAX_W-1:0] zero_reg
  );
    return wr && (rd == src) && (src != zero_reg);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle: ID decode/branch/memory status in,
// enables, flushes, forward and bypass selects and the stall counter out.
interface pipe_hazard_unit_if #(
  parameter int RIDX_W = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [RIDX_W-1:0] id_rn;
  logic [RIDX_W-1:0] id_rm;
  logic              id_rn_used;
  logic              id_rm_used;
  logic [RIDX_W-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_flagset;
  logic              id_flagread;
  logic              br_taken;
  logic              mem_req;
  logic              mem_ready;

  logic              pc_en;
  logic              ifid_en;
  logic              idex_bubble;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_exmem;
  logic              freeze;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              byp_a;
  logic              byp_b;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd,
           id_regwrite, id_memread, id_flagset, id_flagread,
           br_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_bubble, flush_ifid, flush_idex, flush_exmem,
           freeze, fwd_a, fwd_b, byp_a, byp_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd,
           id_regwrite, id_memread, id_flagset, id_flagread,
           br_taken, mem_req, mem_ready,
    output pc_en, ifid_en, idex_bubble, flush_ifid, flush_idex, flush_exmem,
           freeze, fwd_a, fwd_b, byp_a, byp_b, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit_fwd_select.sv
// Per-operand EX forward select: the younger MEM producer beats the WB producer,
// and XZR is never forwarded.
module fwd_select
  import pipe_hazard_pkg::*;
#(
  parameter int ZERO_REG = 31
) (
  input  logic [RIDX_MAX_W-1:0] i_src,
  input  logic                  i_mem_wr,
  input  logic [RIDX_MAX_W-1:0] i_mem_rd,
  input  logic                  i_wb_wr,
  input  logic [RIDX_MAX_W-1:0] i_wb_rd,
  output fwd_sel_t              o_sel
);
  localparam logic [RIDX_MAX_W-1:0] ZR = RIDX_MAX_W'(ZERO_REG);

  // Priority compare: MEM first, then WB, else the register file value
  always_comb begin
    o_sel = FWD_REG;
    if (reg_hit(i_mem_wr, i_mem_rd, i_src, ZR)) begin
      o_sel = FWD_MEM;
    end else if (reg_hit(i_wb_wr, i_wb_rd, i_src, ZR)) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_REG;
    end
  end
endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks EX/MEM/WB in a
// scoreboard and drives stall, flush, freeze, forward and bypass controls.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int RIDX_W   = $clog2(NREG),
  parameter int ZERO_REG = 31,
  parameter int BR_STAGE = STG_MEM,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  pipe_hazard_unit_if.slave bus
);
  localparam logic [RIDX_MAX_W-1:0] ZR = RIDX_MAX_W'(ZERO_REG);

  sb_entry_t             r_ex, r_mem, r_wb;
  sb_entry_t             w_id_entry, w_ex_nxt, w_mem_nxt, w_wb_nxt;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [RIDX_MAX_W-1:0] w_id_rn, w_id_rm, w_id_rd;
  logic                  w_freeze, w_branch, w_load_use, w_flag_haz, w_stall;
  logic                  w_pc_en, w_ifid_en, w_bubble;
  logic                  w_fl_ifid, w_fl_idex, w_fl_exmem;
  logic                  w_mem_wr, w_wb_wr, w_ex_load;
  fwd_sel_t              w_fwd_a, w_fwd_b;
  logic                  w_unused_bits;

  // Widen the ID register indices to the scoreboard field width
  always_comb begin
    w_id_rn = '0;
    w_id_rm = '0;
    w_id_rd = '0;
    w_id_rn[RIDX_W-1:0] = bus.id_rn;
    w_id_rm[RIDX_W-1:0] = bus.id_rm;
    w_id_rd[RIDX_W-1:0] = bus.id_rd;
  end

  // Entry that the instruction currently in ID would occupy in EX
  always_comb begin
    w_id_entry          = '0;
    w_id_entry.valid    = bus.id_valid;
    w_id_entry.rn       = w_id_rn;
    w_id_entry.rm       = w_id_rm;
    w_id_entry.rd       = w_id_rd;
    w_id_entry.regwrite = bus.id_regwrite;
    w_id_entry.memread  = bus.id_memread;
    w_id_entry.flagset  = bus.id_flagset;
  end

  assign w_mem_wr  = r_mem.valid & r_mem.regwrite;
  assign w_wb_wr   = r_wb.valid & r_wb.regwrite;
  assign w_ex_load = bus.id_valid & r_ex.valid & r_ex.memread & r_ex.regwrite;

  assign w_freeze   = bus.mem_req & ~bus.mem_ready;
  assign w_branch   = bus.br_taken & ~w_freeze;
  assign w_load_use = reg_hit(w_ex_load & bus.id_rn_used, r_ex.rd, w_id_rn, ZR)
                    | reg_hit(w_ex_load & bus.id_rm_used, r_ex.rd, w_id_rm, ZR);
  assign w_flag_haz = bus.id_valid & bus.id_flagread & r_ex.valid & r_ex.flagset;
  assign w_stall    = ~w_freeze & ~w_branch & (w_load_use | w_flag_haz);

  // Pipeline register controls: freeze outranks branch flush, which outranks stalls
  always_comb begin
    w_pc_en    = 1'b1;
    w_ifid_en  = 1'b1;
    w_bubble   = 1'b0;
    w_fl_ifid  = 1'b0;
    w_fl_idex  = 1'b0;
    w_fl_exmem = 1'b0;
    if (w_freeze) begin
      w_pc_en   = 1'b0;
      w_ifid_en = 1'b0;
    end else if (w_branch) begin
      w_fl_ifid  = 1'b1;
      w_fl_idex  = 1'b1;
      w_fl_exmem = (BR_STAGE == STG_MEM);
    end else if (w_stall) begin
      w_pc_en   = 1'b0;
      w_ifid_en = 1'b0;
      w_bubble  = 1'b1;
    end else begin
      w_pc_en = 1'b1;
    end
  end

  // Scoreboard advance mirrors what the pipeline registers do this cycle
  always_comb begin
    w_ex_nxt  = w_id_entry;
    w_mem_nxt = r_ex;
    w_wb_nxt  = r_mem;
    if (w_freeze) begin
      w_ex_nxt  = r_ex;
      w_mem_nxt = r_mem;
      w_wb_nxt  = '0;
    end else if (w_branch) begin
      w_ex_nxt = '0;
      if (BR_STAGE == STG_MEM) begin
        w_mem_nxt = '0;
      end else begin
        w_mem_nxt = r_ex;
      end
    end else if (w_stall) begin
      w_ex_nxt = '0;
    end else begin
      w_ex_nxt = w_id_entry;
    end
  end

  // Scoreboard state and saturating stall counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_ex  <= w_ex_nxt;
      r_mem <= w_mem_nxt;
      r_wb  <= w_wb_nxt;
      if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_a (
    .i_src    (r_ex.rn),
    .i_mem_wr (w_mem_wr),
    .i_mem_rd (r_mem.rd),
    .i_wb_wr  (w_wb_wr),
    .i_wb_rd  (r_wb.rd),
    .o_sel    (w_fwd_a)
  );

  fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_b (
    .i_src    (r_ex.rm),
    .i_mem_wr (w_mem_wr),
    .i_mem_rd (r_mem.rd),
    .i_wb_wr  (w_wb_wr),
    .i_wb_rd  (r_wb.rd),
    .o_sel    (w_fwd_b)
  );

  // WB sources and load/flag bits are carried for tracing only
  assign w_unused_bits = ^{r_wb.rn, r_wb.rm, r_wb.memread, r_wb.flagset};

  assign bus.pc_en       = w_pc_en;
  assign bus.ifid_en     = w_ifid_en;
  assign bus.idex_bubble = w_bubble;
  assign bus.flush_ifid  = w_fl_ifid;
  assign bus.flush_idex  = w_fl_idex;
  assign bus.flush_exmem = w_fl_exmem;
  assign bus.freeze      = w_freeze;
  assign bus.fwd_a       = w_fwd_a;
  assign bus.fwd_b       = w_fwd_b;
  assign bus.byp_a       = reg_hit(w_wb_wr, r_wb.rd, w_id_rn, ZR);
  assign bus.byp_b       = reg_hit(w_wb_wr, r_wb.rd, w_id_rm, ZR);
  assign bus.stall_cnt   = r_stall_cnt;
endmodule
